// File: rtl/vga_rx_monitor_if.sv
// VGA video bus: active-low syncs plus 1-bit-per-colour pixel, one pixel per clk.
// master drives the bus (video generator), slave observes it (receiver/monitor).
interface vga_rx_monitor_if;
   logic hsync_n;
   logic vsync_n;
   logic red;
   logic green;
   logic blue;

   modport master (
      output hsync_n,
      output vsync_n,
      output red,
      output green,
      output blue
   );

   modport slave (
      input hsync_n,
      input vsync_n,
      input red,
      input green,
      input blue
   );
endinterface

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: recovers pixel coordinates from the sync edges, verifies
// the sync timing against the configured mode, presents aligned pixels and
// accumulates a 16-bit signature of every complete visible frame.
module vga_rx_monitor #(
   parameter int unsigned HRES = 640,
   parameter int unsigned HF   = 16,
   parameter int unsigned HS   = 96,
   parameter int unsigned HB   = 48,
   parameter int unsigned VRES = 480,
   parameter int unsigned VF   = 10,
   parameter int unsigned VS   = 2,
   parameter int unsigned VB   = 33
) (
   input  logic                   clk,
   input  logic                   reset,
   vga_rx_monitor_if.slave        vga,
   output logic [9:0]             h,
   output logic [9:0]             v,
   output logic [2:0]             rgb_out,
   output logic                   pix_valid,
   output logic                   locked,
   output logic                   frame_done,
   output logic [15:0]            frame_sig,
   output logic [7:0]             frame_count,
   output logic [7:0]             sync_err_count
);

   localparam int unsigned HFULL = HRES + HF + HS + HB;
   localparam int unsigned VFULL = VRES + VF + VS + VB;

   // 10-bit copies of the timing points so every compare is width-matched
   localparam logic [9:0] HSYNC_START = 10'(HRES + HF);
   localparam logic [9:0] VSYNC_START = 10'(VRES + VF);
   localparam logic [9:0] HLAST       = 10'(HFULL - 1);
   localparam logic [9:0] VLAST       = 10'(VFULL - 1);
   localparam logic [9:0] HVIS        = 10'(HRES);
   localparam logic [9:0] VVIS        = 10'(VRES);
   localparam logic [9:0] HVIS_LAST   = 10'(HRES - 1);
   localparam logic [9:0] VVIS_LAST   = 10'(VRES - 1);

   localparam logic [1:0] StSearch  = 2'd0;
   localparam logic [1:0] StAcquire = 2'd1;
   localparam logic [1:0] StLocked  = 2'd2;

   // Signature step: CRC-16-CCITT style shift with the pixel folded into the low bits
   function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [2:0] p);
      return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {13'b0, p};
   endfunction

   logic        hs_q;
   logic        vs_q;
   logic        hs_fall;
   logic        vs_fall;
   logic [9:0]  hc;
   logic [9:0]  vc;
   logic [9:0]  hc_eff;
   logic [9:0]  vc_eff;
   logic [9:0]  hc_next;
   logic [9:0]  vc_next;
   logic        at_hsync;
   logic        at_vsync;
   logic        mismatch;
   logic [1:0]  state;
   logic [1:0]  state_next;
   logic        flag;
   logic        flag_next;
   logic [15:0] acc;
   logic [15:0] sig_base;
   logic [15:0] sig_new;
   logic        frame_end;

   // Sync edge detection and resynchronised pixel counters
   always_comb begin
      hs_fall = ~vga.hsync_n & hs_q;
      vs_fall = ~vga.vsync_n & vs_q;
      // vsync resync takes priority when both edges land together
      if (vs_fall) begin
         hc_eff = 10'd0;
      end else if (hs_fall) begin
         hc_eff = HSYNC_START;
      end else begin
         hc_eff = hc;
      end
      vc_eff  = vs_fall ? VSYNC_START : vc;
      hc_next = (hc_eff == HLAST) ? 10'd0 : hc_eff + 10'd1;
      vc_next = vc_eff;
      if (hc_eff == HLAST) begin
         vc_next = (vc_eff == VLAST) ? 10'd0 : vc_eff + 10'd1;
      end
   end

   // Timing mismatch on the pre-resync counters, and lock FSM next state
   always_comb begin
      at_hsync   = (hc == HSYNC_START);
      at_vsync   = (vc == VSYNC_START) && (hc == 10'd0);
      mismatch   = (hs_fall != at_hsync) || (vs_fall != at_vsync);
      state_next = state;
      flag_next  = flag;
      case (state)
         StSearch: begin
            if (vs_fall) begin
               state_next = StAcquire;
               flag_next  = 1'b0;
            end
         end
         StAcquire: begin
            if (vs_fall) begin
               // A mismatch on the closing edge itself also spoils the frame
               if (!flag && !mismatch) begin
                  state_next = StLocked;
               end
               flag_next = 1'b0;
            end else if (mismatch) begin
               flag_next = 1'b1;
            end
         end
         StLocked: begin
            if (mismatch) begin
               state_next = StSearch;
            end
         end
         default: begin
            state_next = StSearch;
            flag_next  = 1'b0;
         end
      endcase
   end

   // Sync history, counters, lock state and error counter
   always_ff @(posedge clk) begin
      if (reset) begin
         hs_q           <= 1'b1;
         vs_q           <= 1'b1;
         hc             <= 10'd0;
         vc             <= 10'd0;
         state          <= StSearch;
         flag           <= 1'b0;
         sync_err_count <= 8'd0;
      end else begin
         hs_q  <= vga.hsync_n;
         vs_q  <= vga.vsync_n;
         hc    <= hc_next;
         vc    <= vc_next;
         state <= state_next;
         flag  <= flag_next;
         if ((state == StLocked) && (state_next == StSearch) && (sync_err_count != 8'hFF)) begin
            sync_err_count <= sync_err_count + 8'd1;
         end
      end
   end

   // Output stage: pixel with its coordinates, one cycle behind the raw inputs
   always_ff @(posedge clk) begin
      if (reset) begin
         h         <= 10'd0;
         v         <= 10'd0;
         rgb_out   <= 3'd0;
         locked    <= 1'b0;
         pix_valid <= 1'b0;
      end else begin
         h         <= hc_eff;
         v         <= vc_eff;
         rgb_out   <= {vga.red, vga.green, vga.blue};
         // Built from state_next so locked/pix_valid line up with state itself
         locked    <= (state_next == StLocked);
         pix_valid <= (state_next == StLocked) && (hc_eff < HVIS) && (vc_eff < VVIS);
      end
   end

   // Signature step for the pixel currently on the output stage
   always_comb begin
      sig_base  = ((h == 10'd0) && (v == 10'd0)) ? 16'hFFFF : acc;
      sig_new   = sig_step(sig_base, rgb_out);
      frame_end = pix_valid && (h == HVIS_LAST) && (v == VVIS_LAST);
   end

   // Signature accumulator and per-frame result
   always_ff @(posedge clk) begin
      if (reset) begin
         acc         <= 16'd0;
         frame_sig   <= 16'd0;
         frame_done  <= 1'b0;
         frame_count <= 8'd0;
      end else begin
         frame_done <= 1'b0;
         if (pix_valid) begin
            acc <= sig_new;
         end
         if (frame_end) begin
            frame_sig   <= sig_new;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 8'd1;
         end
      end
   end

   // Valid pixels only exist while locked
   assert property (@(posedge clk) disable iff (reset) pix_valid |-> locked);

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a reduced 14x12 mode: lock acquisition,
// frame signature, pixel alignment, sync faults, reset and frame counter wrap.
module tb_vga_rx_monitor;
   localparam int HRES = 8;
   localparam int HF   = 2;
   localparam int HS   = 2;
   localparam int HB   = 2;
   localparam int VRES = 8;
   localparam int VF   = 1;
   localparam int VS   = 2;
   localparam int VB   = 1;
   localparam int HFULL = HRES + HF + HS + HB;
   localparam int VFULL = VRES + VF + VS + VB;
   localparam int HSYNC = HRES + HF;
   localparam int VSYNC = VRES + VF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  h;
   logic [9:0]  v;
   logic [2:0]  rgb_out;
   logic        pix_valid;
   logic        locked;
   logic        frame_done;
   logic [15:0] frame_sig;
   logic [7:0]  frame_count;
   logic [7:0]  sync_err_count;

   vga_rx_monitor_if vga ();

   vga_rx_monitor #(
      .HRES (HRES), .HF (HF), .HS (HS), .HB (HB),
      .VRES (VRES), .VF (VF), .VS (VS), .VB (VB)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .vga            (vga.slave),
      .h              (h),
      .v              (v),
      .rgb_out        (rgb_out),
      .pix_valid      (pix_valid),
      .locked         (locked),
      .frame_done     (frame_done),
      .frame_sig      (frame_sig),
      .frame_count    (frame_count),
      .sync_err_count (sync_err_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Generator position and fault controls
   int          gh = 3;
   int          gv = 2;
   int          last_h = 0;
   int          last_v = 0;
   int          dones = 0;
   int          dones0 = 0;
   bit          rst_req = 1'b1;
   bit          mark = 1'b0;
   bit          hs_delay = 1'b0;
   bit          vs_omit = 1'b0;
   logic [15:0] m_acc = 16'h0000;
   logic [15:0] m_sig = 16'h0000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [2:0] p);
      return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {13'b0, p};
   endfunction

   // Drive one pixel at the falling edge; return just after the sampling edge
   task automatic tick();
      logic [2:0] px;
      bit hlow;
      bit vlow;
      @(negedge clk);
      px = 3'($urandom_range(7, 0));
      if (mark && gv == 7 && gh == 5) px = 3'b101;
      hlow = (gh >= HSYNC) && (gh < HSYNC + HS);
      if (hs_delay && gv == 3) hlow = (gh >= HSYNC + 1) && (gh < HSYNC + HS);
      vlow = (gv >= VSYNC) && (gv < VSYNC + VS) && !vs_omit;
      reset = rst_req;
      vga.hsync_n = ~hlow;
      vga.vsync_n = ~vlow;
      {vga.red, vga.green, vga.blue} = px;
      if (gh < HRES && gv < VRES) begin
         m_acc = sig_step((gh == 0 && gv == 0) ? 16'hFFFF : m_acc, px);
         if (gh == HRES - 1 && gv == VRES - 1) m_sig = m_acc;
      end
      last_h = gh;
      last_v = gv;
      if (gh == HFULL - 1) begin
         gh = 0;
         if (gv == VFULL - 1) begin
            gv = 0;
            hs_delay = 1'b0;
            vs_omit = 1'b0;
         end else begin
            gv++;
         end
      end else begin
         gh++;
      end
      @(posedge clk);
      #1;
      if (frame_done) dones++;
   endtask

   // Run until the raw pixel (vt, ht) has been driven and sampled
   task automatic tick_to(input int vt, input int ht);
      for (int n = 0; n < HFULL * VFULL; n++) begin
         tick();
         if (last_v == vt && last_h == ht) break;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".h"}, 32'(h), 0);
      check({tag, ".v"}, 32'(v), 0);
      check({tag, ".rgb"}, 32'(rgb_out), 0);
      check({tag, ".pix_valid"}, 32'(pix_valid), 0);
      check({tag, ".locked"}, 32'(locked), 0);
      check({tag, ".frame_done"}, 32'(frame_done), 0);
      check({tag, ".frame_sig"}, 32'(frame_sig), 0);
      check({tag, ".frame_count"}, 32'(frame_count), 0);
      check({tag, ".sync_err"}, 32'(sync_err_count), 0);
   endtask

   initial begin
      vga.hsync_n = 1'b1;
      vga.vsync_n = 1'b1;
      vga.red = 1'b0;
      vga.green = 1'b0;
      vga.blue = 1'b0;

      // Reset at an arbitrary phase, then release outside any sync pulse
      repeat (3) tick();
      check_reset_outputs("rst0");
      rst_req = 1'b0;

      // First vs_fall is clean: lock one cycle after the second
      tick_to(VSYNC, 0);
      check("acq1.locked", 32'(locked), 0);
      check("acq1.v", 32'(v), VSYNC);
      tick_to(VSYNC - 1, HFULL - 1);
      check("acq2.pre_locked", 32'(locked), 0);
      tick();
      check("acq2.locked", 32'(locked), 1);
      check("acq2.h", 32'(h), 0);

      // First frame_done right after the next visible region
      tick_to(VRES - 1, HRES - 1);
      check("f1.last_valid", 32'(pix_valid), 1);
      check("f1.pre_done", 32'(frame_done), 0);
      tick();
      check("f1.done", 32'(frame_done), 1);
      check("f1.sig", 32'(frame_sig), 32'(m_sig));
      check("f1.count", 32'(frame_count), 1);
      tick();
      check("f1.done_width", 32'(frame_done), 0);

      // Marker pixel alignment and blanking
      mark = 1'b1;
      tick_to(7, 5);
      check("mark.h", 32'(h), 5);
      check("mark.v", 32'(v), 7);
      check("mark.valid", 32'(pix_valid), 1);
      check("mark.rgb", 32'(rgb_out), 32'b101);
      mark = 1'b0;
      tick_to(7, HRES);
      check("hblank.valid", 32'(pix_valid), 0);
      check("hblank.h", 32'(h), HRES);
      tick_to(VRES, 0);
      check("vblank.valid", 32'(pix_valid), 0);
      check("vblank.locked", 32'(locked), 1);
      tick_to(VFULL - 1, HFULL - 1);
      check("vblank_end.valid", 32'(pix_valid), 0);
      check("f2.count", 32'(frame_count), 2);
      check("f2.sig", 32'(frame_sig), 32'(m_sig));

      // Late hsync edge on line 3: lock drops at the missing edge
      hs_delay = 1'b1;
      dones0 = dones;
      tick_to(3, HSYNC - 1);
      check("hsd.pre_locked", 32'(locked), 1);
      tick();
      check("hsd.locked", 32'(locked), 0);
      check("hsd.err", 32'(sync_err_count), 1);
      tick_to(4, 0);
      check("hsd.valid", 32'(pix_valid), 0);
      tick_to(VSYNC, 0);
      check("hsd.acq_locked", 32'(locked), 0);
      tick_to(VSYNC - 1, HFULL - 1);
      check("hsd.acq_end_locked", 32'(locked), 0);
      tick();
      check("hsd.relock", 32'(locked), 1);
      check("hsd.no_done", 32'(dones - dones0), 0);
      check("hsd.count", 32'(frame_count), 2);

      // Missing vsync pulse: mismatch at (VSYNC, 0)
      tick_to(VFULL - 1, HFULL - 1);
      vs_omit = 1'b1;
      tick_to(VSYNC - 1, HFULL - 1);
      check("vso.count", 32'(frame_count), 3);
      check("vso.pre_locked", 32'(locked), 1);
      tick();
      check("vso.locked", 32'(locked), 0);
      check("vso.err", 32'(sync_err_count), 2);
      check("vso.v", 32'(v), VSYNC);
      tick_to(VSYNC, 0);
      check("vso.acq_locked", 32'(locked), 0);
      tick_to(VSYNC, 0);
      check("vso.relock", 32'(locked), 1);

      // Reset in the middle of a visible line
      tick_to(2, 3);
      check("mrst.pre_valid", 32'(pix_valid), 1);
      rst_req = 1'b1;
      tick();
      check_reset_outputs("mrst");
      rst_req = 1'b0;
      tick_to(VSYNC, 0);
      check("mrst.acq_locked", 32'(locked), 0);
      tick_to(VSYNC, 0);
      check("mrst.relock", 32'(locked), 1);

      // 257 clean frames: counter wraps through 0 to 1, one pulse per frame
      dones0 = dones;
      for (int k = 1; k <= 257; k++) begin
         tick_to(VRES - 1, HRES - 1);
         tick();
         if (k >= 255) check("wrap.done", 32'(frame_done), 1);
         if (k == 255) check("wrap.count255", 32'(frame_count), 255);
         if (k == 256) check("wrap.count0", 32'(frame_count), 0);
         if (k == 257) begin
            check("wrap.count1", 32'(frame_count), 1);
            check("wrap.sig", 32'(frame_sig), 32'(m_sig));
         end
      end
      tick_to(VFULL - 1, HFULL - 1);
      check("wrap.pulses", 32'(dones - dones0), 257);
      check("wrap.err", 32'(sync_err_count), 0);

      // Reset released inside the vsync pulse: spurious edge costs one frame
      tick_to(VSYNC, 5);
      rst_req = 1'b1;
      tick();
      rst_req = 1'b0;
      tick_to(VSYNC, 0);
      check("spur.locked1", 32'(locked), 0);
      tick_to(VSYNC, 0);
      check("spur.locked2", 32'(locked), 1);
      check("spur.err", 32'(sync_err_count), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
